// File: rtl/sci2_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sci2_tx_sched_pkg
// Brief    : Shared SCI2 field-width / line-level macros and TX scheduler
//            state encodings.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef SCI2_VH
`define SCI2_VH
`define SCI2_W_DATA    8
`define SCI2_W_MARK    2
`define SCI2_W_PARITY  1
`define SCI2_W_WORD    (1 + `SCI2_W_DATA + `SCI2_W_MARK + `SCI2_W_PARITY + 1)
`define SCI2_START_BIT 1'b0
`define SCI2_STOP_BIT  1'b1
`endif

package sci2_tx_sched_pkg;

    localparam int c_SCI2_W_WORD = `SCI2_W_WORD;

    typedef enum logic [1:0] {
        SCI2_TXS_IDLE  = 2'd0,
        SCI2_TXS_LOAD  = 2'd1,
        SCI2_TXS_SHIFT = 2'd2,
        SCI2_TXS_GAP   = 2'd3
    } sci2_txs_e;

endpackage

`default_nettype wire

// File: rtl/sci2_tx_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : sci2_tx_sched_rr_pick
// Brief    : One-hot pick of the first set request at or after i_ptr (mod N).
// Revision : 1.0 - initial release
// ============================================================================

module sci2_tx_sched_rr_pick
    import sci2_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_grant
);

    localparam int c_IW = $clog2(N_REQ);

    logic [c_IW-1:0] w_idx;
    logic            w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = c_IW'((int'(i_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sci2_word.sv
`default_nettype none
// ============================================================================
// Module   : sci2_word
// Brief    : SCI2 word framer: start, data, mark, inverted-XOR parity, stop.
// Revision : 1.0 - initial release
// ============================================================================

module sci2_word
    import sci2_tx_sched_pkg::*;
(
    input  logic [`SCI2_W_DATA-1:0] data_in,
    input  logic [`SCI2_W_MARK-1:0] mark_in,
    output logic [`SCI2_W_WORD-1:0] word_out
);

    logic w_parity;

    assign w_parity = ~^{mark_in, data_in};
    assign word_out = {`SCI2_STOP_BIT, w_parity, mark_in, data_in, `SCI2_START_BIT};

endmodule

`default_nettype wire

// File: rtl/sci2_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : sci2_tx_sched
// Brief    : Round-robin scheduler sharing one SCI2 TX line among N_REQ
//            word sources; frames and shifts each word LSB-first.
// Options  : SCI2_TX_FIXED_PRIO_EN - lowest valid index always wins.
// Revision : 1.0 - initial release
// ============================================================================

module sci2_tx_sched
    import sci2_tx_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int BAUD_DIV = 16,
    parameter int GAP_BITS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*`SCI2_W_DATA-1:0] req_data,
    input  logic [N_REQ*`SCI2_W_MARK-1:0] req_mark,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(N_REQ)-1:0]      grant_id
);

    localparam int c_IW = $clog2(N_REQ);
    localparam int c_BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int c_WW = `SCI2_W_WORD;
    localparam int c_NW = $clog2(c_WW);
    localparam int c_GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [c_IW-1:0]  c_ID_LAST   = c_IW'(N_REQ - 1);
    localparam logic [c_BW-1:0]  c_BAUD_LAST = c_BW'(BAUD_DIV - 1);
    localparam logic [c_NW-1:0]  c_BIT_LAST  = c_NW'(c_WW - 1);
    localparam logic [c_GW-1:0]  c_GAP_LAST  = c_GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [N_REQ-1:0] c_ONE       = N_REQ'(1);

    sci2_txs_e                r_state, w_state_nxt;
    logic [c_IW-1:0]          r_grant_id, w_ptr, w_pick_id;
    logic [N_REQ-1:0]         w_pick;
    logic [`SCI2_W_DATA-1:0]  r_data, w_sel_data, w_cap_data;
    logic [`SCI2_W_MARK-1:0]  r_mark, w_sel_mark, w_cap_mark;
    logic [c_WW-1:0]          r_shift, w_word;
    logic [c_BW-1:0]          r_baud;
    logic [c_NW-1:0]          r_bit;
    logic [c_GW-1:0]          r_gap;
    logic                     r_tx, w_sel_valid, w_load_ok, w_baud_end;

    sci2_tx_sched_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_pick)
    );

    // Fixed priority is the round-robin picker with its pointer parked at 0.
`ifdef SCI2_TX_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [c_IW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (w_load_ok)
            r_ptr <= (r_grant_id == c_ID_LAST) ? '0 : r_grant_id + 1'b1;
    end

    assign w_ptr = r_ptr;
`endif

    always_comb begin
        w_pick_id = '0;
        for (int i = 0; i < N_REQ; i++)
            if (w_pick[i]) w_pick_id = c_IW'(i);
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_mark  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant_id == c_IW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_data  = req_data[i*`SCI2_W_DATA +: `SCI2_W_DATA];
                w_sel_mark  = req_mark[i*`SCI2_W_MARK +: `SCI2_W_MARK];
            end
        end
    end

    assign w_load_ok  = (r_state == SCI2_TXS_LOAD) && w_sel_valid;
    assign w_baud_end = (r_baud == c_BAUD_LAST);

    // The framer sees the capture registers' next value so the shift register
    // can load the finished word on the same edge that captures the fields.
    assign w_cap_data = w_load_ok ? w_sel_data : r_data;
    assign w_cap_mark = w_load_ok ? w_sel_mark : r_mark;

    sci2_word u_word (
        .data_in  (w_cap_data),
        .mark_in  (w_cap_mark),
        .word_out (w_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= SCI2_TXS_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != SCI2_TXS_IDLE);
        req_ready   = w_load_ok ? (c_ONE << r_grant_id) : '0;
        case (r_state)
            SCI2_TXS_IDLE:  if (|req_valid) w_state_nxt = SCI2_TXS_LOAD;
            SCI2_TXS_LOAD:  w_state_nxt = w_sel_valid ? SCI2_TXS_SHIFT : SCI2_TXS_IDLE;
            SCI2_TXS_SHIFT: if (w_baud_end && (r_bit == c_BIT_LAST))
                                w_state_nxt = (GAP_BITS == 0) ? SCI2_TXS_IDLE : SCI2_TXS_GAP;
            SCI2_TXS_GAP:   if (w_baud_end && (r_gap == c_GAP_LAST))
                                w_state_nxt = SCI2_TXS_IDLE;
            default:        w_state_nxt = SCI2_TXS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant_id <= '0;
            r_tx       <= `SCI2_STOP_BIT;
            r_data     <= '0;
            r_mark     <= '0;
            r_shift    <= '0;
            r_baud     <= '0;
            r_bit      <= '0;
            r_gap      <= '0;
        end else begin
            case (r_state)
                SCI2_TXS_IDLE: if (|req_valid) r_grant_id <= w_pick_id;
                SCI2_TXS_LOAD: begin
                    if (w_load_ok) begin
                        r_data  <= w_sel_data;
                        r_mark  <= w_sel_mark;
                        r_shift <= w_word;
                        r_tx    <= w_word[0];
                        r_baud  <= '0;
                        r_bit   <= '0;
                    end
                end
                SCI2_TXS_SHIFT: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == c_BIT_LAST) begin
                            r_tx  <= `SCI2_STOP_BIT;
                            r_gap <= '0;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                SCI2_TXS_GAP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        r_gap  <= r_gap + 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_out   = r_tx;
    assign grant_id = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_sci2_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sci2_tx_sched
// Brief    : Scoreboard bench for sci2_tx_sched (BAUD_DIV=4, GAP 2 and GAP 0).
// Revision : 1.0 - initial release
// ============================================================================

`ifndef SCI2_VH
`define SCI2_VH
`define SCI2_W_DATA    8
`define SCI2_W_MARK    2
`define SCI2_W_PARITY  1
`define SCI2_W_WORD    (1 + `SCI2_W_DATA + `SCI2_W_MARK + `SCI2_W_PARITY + 1)
`define SCI2_START_BIT 1'b0
`define SCI2_STOP_BIT  1'b1
`endif

module tb_sci2_tx_sched;

    localparam int c_N    = 4;
    localparam int c_BAUD = 4;
    localparam int c_WD   = `SCI2_W_DATA;
    localparam int c_WM   = `SCI2_W_MARK;
    localparam int c_WW   = `SCI2_W_WORD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [c_N-1:0]        req_valid, req_ready;
    logic [c_N*c_WD-1:0]   req_data;
    logic [c_N*c_WM-1:0]   req_mark;
    logic                  tx_out, busy;
    logic [1:0]            grant_id;

    logic [c_N-1:0]        g0_valid, g0_ready;
    logic [c_N*c_WD-1:0]   g0_data;
    logic [c_N*c_WM-1:0]   g0_mark;
    logic                  g0_tx, g0_busy;
    logic [1:0]            g0_gid;

    sci2_tx_sched #(.N_REQ(c_N), .BAUD_DIV(c_BAUD), .GAP_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_mark(req_mark), .req_ready(req_ready), .tx_out(tx_out),
        .busy(busy), .grant_id(grant_id)
    );

    sci2_tx_sched #(.N_REQ(c_N), .BAUD_DIV(c_BAUD), .GAP_BITS(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .req_valid(g0_valid), .req_data(g0_data),
        .req_mark(g0_mark), .req_ready(g0_ready), .tx_out(g0_tx),
        .busy(g0_busy), .grant_id(g0_gid)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_rdy   = 0;

    logic [c_WD+c_WM-1:0] pend_q [c_N][$];
    int                   exp_gnt_q[$];
    logic [c_WW-1:0]      exp_word_q[$];
    logic [c_N-1:0]       rdy_seen = '0;

    logic                 rx_active = 1'b0;
    int                   rx_n = 0;
    logic [c_WW*c_BAUD-1:0] rx_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [c_WW-1:0] frame(input logic [c_WD-1:0] d, input logic [c_WM-1:0] m);
        logic p;
        p = (($countones({m, d}) % 2) == 0);
        return {1'b1, p, m, d, 1'b0};
    endfunction

    function automatic int onehot_idx(input logic [c_N-1:0] v);
        int r = -1;
        for (int i = 0; i < c_N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic expect_word(input int i, input logic [c_WD-1:0] d, input logic [c_WM-1:0] m);
        exp_gnt_q.push_back(i);
        exp_word_q.push_back(frame(d, m));
    endtask

    task automatic tick_drive();
        @(posedge clk);
        #1;
        for (int i = 0; i < c_N; i++) begin
            if (rdy_seen[i] && pend_q[i].size() > 0) void'(pend_q[i].pop_front());
            if (pend_q[i].size() > 0) begin
                req_valid[i] = 1'b1;
                {req_mark[i*c_WM +: c_WM], req_data[i*c_WD +: c_WD]} = pend_q[i][0];
            end else if (rdy_seen[i]) begin
                req_valid[i] = 1'b0;
            end
        end
        rdy_seen = '0;
    endtask

    task automatic tick_mon();
        logic [c_WW-1:0] got;
        int              unst;
        int              gi;
        @(negedge clk);
        rdy_seen = req_ready;
        if (req_ready != '0) begin
            n_rdy++;
            check("rdy_onehot", $countones(req_ready), 1);
            if (exp_gnt_q.size() == 0) begin
                check("rdy_unexpected", req_ready, 0);
            end else begin
                gi = exp_gnt_q.pop_front();
                check("grant_rdy", onehot_idx(req_ready), gi);
                check("grant_id", grant_id, gi);
            end
        end
        if (!rst_n) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && tx_out == 1'b0) begin
                rx_active = 1'b1;
                rx_n      = 0;
            end
            if (rx_active) begin
                rx_s[rx_n] = tx_out;
                rx_n++;
                if (rx_n == c_WW*c_BAUD) begin
                    rx_active = 1'b0;
                    unst = 0;
                    for (int b = 0; b < c_WW; b++) begin
                        got[b] = rx_s[b*c_BAUD+1];
                        for (int k = 0; k < c_BAUD; k++)
                            if (rx_s[b*c_BAUD+k] !== rx_s[b*c_BAUD]) unst++;
                    end
                    if (exp_word_q.size() == 0) begin
                        check("word_unexpected", got, 0);
                    end else begin
                        check("word", got, exp_word_q.pop_front());
                        check("bit_stable", unst, 0);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        tick_drive();
        tick_mon();
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || rx_active || exp_word_q.size() != 0 || pend_q[0].size() != 0 ||
                pend_q[1].size() != 0 || pend_q[2].size() != 0 || pend_q[3].size() != 0) &&
               n < bound) begin
            tick();
            n++;
        end
        check("idle_busy", busy, 0);
        check("idle_queues", exp_word_q.size() + exp_gnt_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < c_N; i++) pend_q[i].delete();
        exp_gnt_q.delete();
        exp_word_q.delete();
        req_valid = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    int              n, p, q, rc;
    logic            s [120];
    logic [c_WW-1:0] gw;

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_mark = '0;
        g0_valid  = '0; g0_data  = '0; g0_mark  = '0;
        repeat (2) tick();
        check("rst_tx", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_gid", grant_id, 0);
        check("rst_ready", req_ready, 0);
        check("rst_g0_tx", g0_tx, 1);
        rst_n = 1'b1;
        tick();

        // single word from requester 0, latency and word length
        pend_q[0].push_back({2'b00, 8'h00});
        expect_word(0, 8'h00, 2'b00);
        tick();
        check("a_ready_idle", req_ready, 0);
        check("a_busy_idle", busy, 0);
        tick();
        check("a_ready_t1", req_ready, 4'b0001);
        check("a_busy_load", busy, 1);
        check("a_tx_load", tx_out, 1);
        tick();
        check("a_start_t2", tx_out, 0);
        check("a_ready_off", req_ready, 0);
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        check("a_busy_len", n, (c_WW + 2) * c_BAUD);
        wait_idle(100);

        // parity and data patterns
        pend_q[0].push_back({2'b00, 8'h01});
        expect_word(0, 8'h01, 2'b00);
        pend_q[0].push_back({2'b11, 8'hA5});
        expect_word(0, 8'hA5, 2'b11);
        wait_idle(400);

        // all four requesters contending, two words each
        do_reset();
        n_rdy = 0;
        for (int i = 0; i < c_N; i++)
            for (int k = 0; k < 2; k++)
                pend_q[i].push_back({2'(i), 8'(8'h10 * i + k + 1)});
`ifdef SCI2_TX_FIXED_PRIO_EN
        for (int i = 0; i < c_N; i++)
            for (int k = 0; k < 2; k++)
                expect_word(i, 8'(8'h10 * i + k + 1), 2'(i));
`else
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < c_N; i++)
                expect_word(i, 8'(8'h10 * i + k + 1), 2'(i));
`endif
        wait_idle(2000);
        check("c_ready_cnt", n_rdy, 8);

        // move pointer to 2, then requester 2 withdraws during LOAD
        pend_q[1].push_back({2'b01, 8'h3C});
        expect_word(1, 8'h3C, 2'b01);
        wait_idle(300);
        req_data[2*c_WD +: c_WD] = 8'hFF;
        req_valid[2] = 1'b1;
        tick_drive();
        req_valid[2] = 1'b0;
        tick_mon();
        check("d_ready_none", req_ready, 0);
        check("d_busy_load", busy, 1);
        check("d_gid", grant_id, 2);
        tick();
        check("d_back_idle", busy, 0);
        check("d_tx_idle", tx_out, 1);
        tick();
        check("d_tx_idle2", tx_out, 1);
        pend_q[0].push_back({2'b10, 8'h81});
        pend_q[2].push_back({2'b01, 8'h42});
`ifdef SCI2_TX_FIXED_PRIO_EN
        expect_word(0, 8'h81, 2'b10);
        expect_word(2, 8'h42, 2'b01);
`else
        expect_word(2, 8'h42, 2'b01);
        expect_word(0, 8'h81, 2'b10);
`endif
        wait_idle(400);

        // reset in the middle of bit 5
        pend_q[3].push_back({2'b00, 8'h00});
        expect_word(3, 8'h00, 2'b00);
        n = 0;
        while (tx_out != 1'b0 && n < 20) begin tick(); n++; end
        check("e_start", tx_out, 0);
        repeat (5 * c_BAUD + 1) tick();
        check("e_gid_pre", grant_id, 3);
        check("e_tx_bit5", tx_out, 0);
        check("e_busy_pre", busy, 1);
        rst_n = 1'b0;
        tick();
        check("e_tx_rst", tx_out, 1);
        check("e_busy_rst", busy, 0);
        check("e_gid_rst", grant_id, 0);
        check("e_ready_rst", req_ready, 0);
        exp_word_q.delete();
        rst_n = 1'b1;
        tick();

        // complete word after reset release
        pend_q[1].push_back({2'b10, 8'h5A});
        expect_word(1, 8'h5A, 2'b10);
        wait_idle(300);

        // back-to-back words with no gap
        g0_data[c_WD-1:0] = 8'h01;
        g0_mark[c_WM-1:0] = 2'b00;
        g0_valid = 4'b0001;
        rc = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            s[k] = g0_tx;
            if (g0_ready != '0) rc++;
        end
        g0_valid = '0;
        p = -1;
        for (int k = 0; k < 120; k++) if (p < 0 && s[k] == 1'b0) p = k;
        check("g_first_start", p, 1);
        q = -1;
        if (p >= 0)
            for (int k = p + 48; k < 120; k++) if (q < 0 && s[k] == 1'b0) q = k;
        check("g_next_start", q - p, c_WW * c_BAUD + 2);
        gw = '0;
        if (p >= 0)
            for (int b = 0; b < c_WW; b++) gw[b] = s[p + b*c_BAUD + 1];
        check("g_word", gw, frame(8'h01, 2'b00));
        check("g_ready_cnt", rc, 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sci2_tx_sched.md
Name: sci2_tx_sched

Overview:
Round-robin transmit scheduler that shares one SCI2 serial line between N_REQ word sources. It arbitrates among pending requests and captures the winner's data and mark fields. The captured fields are framed into an SCI2 word (start bit, data, mark, inverted-XOR parity, stop bit). The word is shifted out LSB-first at a fixed bit period, followed by an idle gap. It sits between the cyclogram word producers and the physical SCI2 TX pin.

Parameters:
N_REQ, 4, number of requesters (2..16)
BAUD_DIV, 16, clk cycles per serial bit (>=1)
GAP_BITS, 2, idle bit periods inserted after each stop bit (>=0; 0 = back-to-back)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active low
req_valid  in  N_REQ  per-requester word pending
req_data  in  N_REQ*`SCI2_W_DATA  packed data fields; requester i at slice i
req_mark  in  N_REQ*`SCI2_W_MARK  packed mark fields; requester i at slice i
req_ready  out  N_REQ  one-hot capture strobe, one cycle wide
tx_out  out  1  serial line
busy  out  1  high whenever state != IDLE
grant_id  out  $clog2(N_REQ)  index of last granted requester

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous and active low. All state updates occur on the clk rising edge, including reset.
- Reset values: state=IDLE, req_ready=0, tx_out=`SCI2_STOP_BIT (idle level), busy=0, grant_id=0, RR pointer=0, all counters=0.
- Reset mid-word: the word is abandoned. tx_out returns to idle level at the reset edge. No req_ready is issued.
- FSM: IDLE -> LOAD -> SHIFT -> GAP -> IDLE. GAP is skipped when GAP_BITS=0.
- IDLE: if any req_valid is high, grant the first valid index at or after the RR pointer (wrapping mod N_REQ). Register the index in grant_id and go to LOAD.
- LOAD, normal case: if req_valid[grant_id] is still high, pulse req_ready[grant_id] this cycle and capture that requester's data/mark. Set RR pointer to (grant_id+1) mod N_REQ and go to SHIFT.
- LOAD, valid withdrawn: if req_valid[grant_id] has dropped (protocol violation), return to IDLE. No ready pulse; pointer unchanged.
- Handshake: requesters must hold valid, data and mark stable until their ready pulse. The pulse in LOAD is the only capture point.
- Word format (`SCI2_W_WORD bits, index 0 first): [0]=`SCI2_START_BIT, [W_DATA:1]=data, next W_MARK bits=mark, then parity bit = ~^{mark,data}, then MSB=`SCI2_STOP_BIT.
- SHIFT: each bit is held on tx_out for exactly BAUD_DIV cycles. The start bit appears on the cycle after LOAD.
- Latency: valid seen in IDLE at cycle t -> ready at t+1 -> start bit at t+2.
- Word length: SHIFT lasts `SCI2_W_WORD*BAUD_DIV cycles.
- GAP: tx_out held at idle level for GAP_BITS*BAUD_DIV cycles, then IDLE. New requests are evaluated only in IDLE.
- Simultaneous valids are resolved by the RR pointer; each granted requester becomes lowest priority next round.
- Fairness: with all N_REQ valid continuously, grants cycle 0,1,..,N_REQ-1,0.
- tx_out is driven from a flop (glitch-free).
- Counters: baud counter width $clog2(BAUD_DIV) (min 1); bit counter width $clog2(`SCI2_W_WORD). Both wrap only under FSM control.

Optional Feature:
SCI2_TX_FIXED_PRIO_EN
- Defined: the RR pointer is removed. IDLE always grants the lowest valid index. grant_id behaviour is unchanged.
- Undefined: round-robin as above.

Decomposition:
- Shared header sci2.vh holds the field-width macros (`SCI2_W_DATA, `SCI2_W_MARK, `SCI2_W_PARITY, `SCI2_W_WORD) and the line-level macros (`SCI2_START_BIT, `SCI2_STOP_BIT).
- Add to the header: state encodings SCI2_TXS_IDLE/LOAD/SHIFT/GAP.
- Framing: one instance of the existing sci2_word framer, fed from the captured data/mark registers. Its word_out is loaded into the shift register on the LOAD->SHIFT transition.
- Arbitration: an rr_pick sub-module (request vector + pointer in, one-hot grant out) is natural and reused by the fixed-priority variant with pointer tied to 0.

Test Plan:
- BAUD_DIV=4, requester 0 sends data=0, mark=0: ready[0] pulses at t+1; line = start, zeros, parity=1, stop; each bit held 4 cycles; busy low again after (W_WORD+2)*4 cycles.
- Data=1, mark=0: parity bit=0, and bit[1] on line is 1.
- All four valid continuously for 8 words: grant order 0,1,2,3,0,1,2,3; exactly one ready per word.
- Same run with SCI2_TX_FIXED_PRIO_EN defined: requester 0 wins every word.
- Requester 2 drops valid during LOAD: no ready pulse, FSM back to IDLE, tx_out stays idle, next grant still starts search at the old pointer.
- rst_n low mid-SHIFT (bit 5): at the next edge tx_out=idle, busy=0, grant_id=0.
- After release, a new request transmits a complete correct word.
- GAP_BITS=0 with a continuous request: stop bit of word n is followed directly by the start bit of word n+1 after IDLE and LOAD (2-cycle idle-level pause).
